// File: rtl/prev_knn_streamer_if.sv
// Shared neighbour-entry type and the handshake bundle around prev_knn_streamer
// (query source, topK writeback, comparator-facing stream).
`ifndef B
`define B 16
`endif

package prev_knn_pkg;
  localparam int COORD_W = 10;
  localparam int ID_W    = 8;
  localparam int DIST_W  = `B;

  typedef logic signed [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t            x;
    coord_t            y;
    coord_t            z;
    logic [ID_W-1:0]   point_id;
    logic [DIST_W-1:0] distance;
    logic              valid;
  } knn_entry_t;
endpackage

interface prev_knn_streamer_if;
  import prev_knn_pkg::*;

  logic       query_valid;
  logic       query_ready;
  coord_t     query_x;
  coord_t     query_y;
  coord_t     query_z;
  logic       wb_valid;
  logic       wb_ready;
  knn_entry_t wb_entry;
  logic       wb_last;
  knn_entry_t prev_knn_point_out;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       stream_done;

  modport master (
    output query_valid, query_x, query_y, query_z,
    output wb_valid, wb_entry, wb_last, out_ready,
    input  query_ready, wb_ready, prev_knn_point_out, out_valid, out_last, stream_done
  );

  modport slave (
    input  query_valid, query_x, query_y, query_z,
    input  wb_valid, wb_entry, wb_last, out_ready,
    output query_ready, wb_ready, prev_knn_point_out, out_valid, out_last, stream_done
  );
endinterface

// File: rtl/prev_knn_streamer.sv
// Holds the previous query's K-neighbour list and, per accepted query, streams all K
// entries with squared distance recomputed against the new query point.
module prev_knn_streamer
  import prev_knn_pkg::*;
#(
  parameter  int K     = 8,
  localparam int PTR_W = $clog2(K) + 1
) (
  input  logic               clock,
  input  logic               reset,
  prev_knn_streamer_if.slave io
);
  localparam int IDX_W = $clog2(K);
  localparam int SUM_W = 2 * (COORD_W + 1) + 2;

  typedef enum logic [1:0] {EMPTY, HOLD, STREAM} state_e;

  state_e           state_q, state_d;
  logic             list_valid_q, list_valid_d;
  logic             wb_busy_q, wb_busy_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  knn_entry_t       mem_q [K];
  knn_entry_t       mem_d [K];
  coord_t           qx_q, qy_q, qz_q, qx_d, qy_d, qz_d;
  knn_entry_t       out_dat_q, out_dat_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             done_q, done_d;

  logic             query_rdy, wb_rdy, q_fire, wb_fire, load;
  logic [PTR_W-1:0] wr_idx;
  knn_entry_t       src, nxt_out;
  coord_t           sx, sy, sz;

  function automatic logic [DIST_W-1:0] sq_dist(knn_entry_t e, coord_t qx, coord_t qy, coord_t qz);
    logic signed [SUM_W-1:0] dx, dy, dz;
    logic        [SUM_W-1:0] sum;
    dx  = SUM_W'(e.x) - SUM_W'(qx);
    dy  = SUM_W'(e.y) - SUM_W'(qy);
    dz  = SUM_W'(e.z) - SUM_W'(qz);
    sum = $unsigned(dx * dx + dy * dy + dz * dz);
    return (|sum[SUM_W-1:DIST_W]) ? '1 : sum[DIST_W-1:0];
  endfunction

  // A half-written list blocks queries; a query in the same cycle as a writeback wins.
  assign query_rdy = (state_q != STREAM) && !wb_busy_q;
  assign wb_rdy    = (state_q != STREAM) && !(io.query_valid && query_rdy);
  assign q_fire    = io.query_valid && query_rdy;
  assign wb_fire   = io.wb_valid && wb_rdy;
  assign load      = !out_valid_q || io.out_ready;
  assign wr_idx    = wb_busy_q ? wr_ptr_q : '0;

  assign io.query_ready        = query_rdy;
  assign io.wb_ready           = wb_rdy;
  assign io.prev_knn_point_out = out_dat_q;
  assign io.out_valid          = out_valid_q;
  assign io.out_last           = out_last_q;
  assign io.stream_done        = done_q;

  // The acceptance cycle feeds the live query and slot 0 so the first beat is not delayed.
  always_comb begin
    src              = q_fire ? mem_q[0] : mem_q[rd_ptr_q[IDX_W-1:0]];
    sx               = q_fire ? io.query_x : qx_q;
    sy               = q_fire ? io.query_y : qy_q;
    sz               = q_fire ? io.query_z : qz_q;
    nxt_out          = src;
    nxt_out.distance = sq_dist(src, sx, sy, sz);
  end

  always_comb begin
    state_d      = state_q;
    list_valid_d = list_valid_q;
    wb_busy_d    = wb_busy_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    mem_d        = mem_q;
    qx_d         = qx_q;
    qy_d         = qy_q;
    qz_d         = qz_q;
    out_dat_d    = out_dat_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    done_d       = 1'b0;

    if (wb_fire) begin
      for (int i = 0; i < K; i++) begin
        if (PTR_W'(i) == wr_idx) begin
          mem_d[i]          = io.wb_entry;
          mem_d[i].distance = '0;
        end else if (io.wb_last && PTR_W'(i) > wr_idx) begin
          mem_d[i] = '0;
        end
      end
      wr_ptr_d = (wr_idx < PTR_W'(K)) ? wr_idx + PTR_W'(1) : wr_idx;
      if (io.wb_last) begin
        wb_busy_d    = 1'b0;
        list_valid_d = 1'b1;
        state_d      = HOLD;
      end else begin
        wb_busy_d    = 1'b1;
        list_valid_d = 1'b0;
        state_d      = EMPTY;
      end
    end

    if (q_fire) begin
      if (list_valid_q) begin
        qx_d        = io.query_x;
        qy_d        = io.query_y;
        qz_d        = io.query_z;
        out_dat_d   = nxt_out;
        out_valid_d = 1'b1;
        out_last_d  = (K == 1);
        rd_ptr_d    = PTR_W'(1);
        state_d     = STREAM;
      end else begin
        done_d = 1'b1;
      end
    end

    if (state_q == STREAM && load) begin
      if (out_valid_q && out_last_q) begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        done_d      = 1'b1;
        state_d     = HOLD;
      end else begin
        out_dat_d   = nxt_out;
        out_valid_d = 1'b1;
        out_last_d  = (rd_ptr_q == PTR_W'(K - 1));
        rd_ptr_d    = rd_ptr_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= EMPTY;
      list_valid_q <= 1'b0;
      wb_busy_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      mem_q        <= '{default: '0};
      qx_q         <= '0;
      qy_q         <= '0;
      qz_q         <= '0;
      out_dat_q    <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      list_valid_q <= list_valid_d;
      wb_busy_q    <= wb_busy_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      mem_q        <= mem_d;
      qx_q         <= qx_d;
      qy_q         <= qy_d;
      qz_q         <= qz_d;
      out_dat_q    <= out_dat_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      done_q       <= done_d;
    end
  end
endmodule

// File: tb/tb_prev_knn_streamer.sv
// Randomised bench for prev_knn_streamer against a queue-based reference model.
module tb_prev_knn_streamer;
  import prev_knn_pkg::*;

  localparam int K = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  prev_knn_streamer_if ifc ();

  prev_knn_streamer #(.K(K)) dut (
    .clock (clock),
    .reset (reset),
    .io    (ifc)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the held list, the list under construction, and the beats still owed.
  knn_entry_t list_m [K];
  knn_entry_t wb_acc [$];
  knn_entry_t exp_q  [$];
  bit         list_ok, building, done_pend;
  bit         last_qf, last_wf;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic knn_entry_t exp_entry(knn_entry_t e, coord_t qx, coord_t qy, coord_t qz);
    knn_entry_t r;
    longint dx  = longint'(e.x) - longint'(qx);
    longint dy  = longint'(e.y) - longint'(qy);
    longint dz  = longint'(e.z) - longint'(qz);
    longint s   = dx * dx + dy * dy + dz * dz;
    longint lim = longint'(1) << DIST_W;
    r = e;
    if (s >= lim) r.distance = '1;
    else          r.distance = DIST_W'(s);
    return r;
  endfunction

  function automatic knn_entry_t mk(int x, int y, int z, int id, bit v);
    knn_entry_t e;
    e.x        = coord_t'(x);
    e.y        = coord_t'(y);
    e.z        = coord_t'(z);
    e.point_id = ID_W'(id);
    e.distance = DIST_W'($urandom);
    e.valid    = v;
    return e;
  endfunction

  function automatic coord_t rnd_coord();
    logic [31:0] r = $urandom;
    if (r[31]) return coord_t'(r[9:0]);
    return coord_t'(int'(r[3:0]) - 8);
  endfunction

  task automatic model_reset();
    list_ok   = 1'b0;
    building  = 1'b0;
    done_pend = 1'b0;
    exp_q.delete();
    wb_acc.delete();
    for (int i = 0; i < K; i++) list_m[i] = '0;
  endtask

  // Called just after a falling edge with inputs already driven; returns one cycle later.
  task automatic step();
    bit         exp_ov, exp_qr, exp_wr, of;
    knn_entry_t e;
    #1;
    exp_ov = exp_q.size() > 0;
    exp_qr = !exp_ov && !building;
    exp_wr = !exp_ov && !(ifc.query_valid && exp_qr);
    check_eq("out_valid",   64'(ifc.out_valid),   64'(exp_ov));
    check_eq("query_ready", 64'(ifc.query_ready), 64'(exp_qr));
    check_eq("wb_ready",    64'(ifc.wb_ready),    64'(exp_wr));
    check_eq("stream_done", 64'(ifc.stream_done), 64'(done_pend));
    if (exp_ov) begin
      check_eq("out_entry", 64'(ifc.prev_knn_point_out), 64'(exp_q[0]));
      check_eq("out_last",  64'(ifc.out_last),           64'(exp_q.size() == 1));
    end
    last_qf   = ifc.query_valid && exp_qr;
    last_wf   = ifc.wb_valid && exp_wr;
    of        = exp_ov && ifc.out_ready;
    done_pend = 1'b0;
    if (of) begin
      void'(exp_q.pop_front());
      if (exp_q.size() == 0) done_pend = 1'b1;
    end
    if (last_qf) begin
      if (list_ok) begin
        for (int i = 0; i < K; i++)
          exp_q.push_back(exp_entry(list_m[i], ifc.query_x, ifc.query_y, ifc.query_z));
      end else begin
        done_pend = 1'b1;
      end
    end
    if (last_wf) begin
      if (!building) begin
        wb_acc.delete();
        list_ok  = 1'b0;
        building = 1'b1;
      end
      e          = ifc.wb_entry;
      e.distance = '0;
      if (wb_acc.size() < K) wb_acc.push_back(e);
      if (ifc.wb_last) begin
        for (int i = 0; i < K; i++) begin
          if (i < wb_acc.size()) list_m[i] = wb_acc[i];
          else                   list_m[i] = '0;
        end
        list_ok  = 1'b1;
        building = 1'b0;
      end
    end
    @(negedge clock);
  endtask

  task automatic drive_ready(int mode, int c);
    case (mode)
      0:       ifc.out_ready = 1'b1;
      1:       ifc.out_ready = (c % 2 == 0);
      default: ifc.out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic idle(int n, int mode);
    for (int c = 0; c < n; c++) begin
      drive_ready(mode, c);
      step();
    end
  endtask

  task automatic send_wb(knn_entry_t e, bit last);
    bit got = 1'b0;
    ifc.wb_valid = 1'b1;
    ifc.wb_entry = e;
    ifc.wb_last  = last;
    for (int c = 0; c < 100 && !got; c++) begin
      step();
      got = last_wf;
    end
    ifc.wb_valid = 1'b0;
    ifc.wb_last  = 1'b0;
    check_eq("wb_accept", 64'(got), 64'(1));
  endtask

  task automatic send_query(int x, int y, int z);
    bit got = 1'b0;
    ifc.query_valid = 1'b1;
    ifc.query_x     = coord_t'(x);
    ifc.query_y     = coord_t'(y);
    ifc.query_z     = coord_t'(z);
    for (int c = 0; c < 100 && !got; c++) begin
      step();
      got = last_qf;
    end
    ifc.query_valid = 1'b0;
    check_eq("query_accept", 64'(got), 64'(1));
  endtask

  task automatic drain(int mode);
    int c = 0;
    while ((exp_q.size() > 0 || done_pend) && c < 200) begin
      drive_ready(mode, c);
      step();
      c++;
    end
    check_eq("drain_left", 64'(exp_q.size()), 64'(0));
    idle(1, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.query_valid = 1'b0;
    ifc.query_x     = '0;
    ifc.query_y     = '0;
    ifc.query_z     = '0;
    ifc.wb_valid    = 1'b0;
    ifc.wb_entry    = '0;
    ifc.wb_last     = 1'b0;
    ifc.out_ready   = 1'b0;
    model_reset();

    #1;
    check_eq("rst_out_valid",   64'(ifc.out_valid),          64'(0));
    check_eq("rst_out_last",    64'(ifc.out_last),           64'(0));
    check_eq("rst_stream_done", 64'(ifc.stream_done),        64'(0));
    check_eq("rst_out_entry",   64'(ifc.prev_knn_point_out), 64'(0));
    check_eq("rst_query_ready", 64'(ifc.query_ready),        64'(1));
    check_eq("rst_wb_ready",    64'(ifc.wb_ready),           64'(1));
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    idle(2, 0);

    // No list held: a query only produces a done pulse.
    send_query(0, 0, 0);
    idle(3, 0);

    // Eight points along x, streamed back-to-back.
    for (int i = 0; i < K; i++) send_wb(mk(i, 0, 0, 16 + i, 1'b1), i == K - 1);
    ifc.out_ready = 1'b1;
    send_query(0, 0, 0);
    drain(0);

    // Query and writeback together while holding: query wins; then a stalling consumer.
    ifc.query_valid = 1'b1;
    ifc.query_x     = coord_t'(3);
    ifc.query_y     = coord_t'(-2);
    ifc.query_z     = coord_t'(1);
    ifc.wb_valid    = 1'b1;
    ifc.wb_entry    = mk(9, 9, 9, 99, 1'b1);
    ifc.wb_last     = 1'b1;
    ifc.out_ready   = 1'b1;
    step();
    check_eq("query_wins", 64'(last_qf), 64'(1));
    ifc.query_valid = 1'b0;
    ifc.wb_valid    = 1'b0;
    ifc.wb_last     = 1'b0;
    drain(1);

    // Short list: remaining slots stream as invalid.
    for (int i = 0; i < 3; i++) send_wb(mk(int'(rnd_coord()), int'(rnd_coord()), int'(rnd_coord()), 40 + i, 1'b1), i == 2);
    send_query(int'(rnd_coord()), int'(rnd_coord()), int'(rnd_coord()));
    drain(2);

    // Extreme coordinates saturate the distance.
    send_wb(mk(511, 0, 0, 5, 1'b1), 1'b1);
    send_query(-512, 0, 0);
    drain(0);

    // Reset while the third beat is on the output.
    for (int i = 0; i < K; i++) send_wb(mk(int'(rnd_coord()), int'(rnd_coord()), 0, 60 + i, 1'b1), i == K - 1);
    ifc.out_ready = 1'b1;
    send_query(1, 1, 1);
    idle(2, 0);
    reset = 1'b1;
    #1;
    check_eq("midrst_out_valid",   64'(ifc.out_valid),   64'(0));
    check_eq("midrst_stream_done", 64'(ifc.stream_done), 64'(0));
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    idle(1, 0);
    send_query(2, 2, 2);
    idle(3, 0);

    // Free-running random traffic.
    for (int c = 0; c < 600; c++) begin
      ifc.query_valid = ($urandom_range(0, 9) == 0);
      ifc.query_x     = rnd_coord();
      ifc.query_y     = rnd_coord();
      ifc.query_z     = rnd_coord();
      ifc.wb_valid    = ($urandom_range(0, 2) == 0);
      ifc.wb_entry    = mk(int'(rnd_coord()), int'(rnd_coord()), int'(rnd_coord()), int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      ifc.wb_last     = ($urandom_range(0, 5) == 0);
      ifc.out_ready   = ($urandom_range(0, 3) != 0);
      step();
    end
    ifc.query_valid = 1'b0;
    ifc.wb_valid    = 1'b0;
    ifc.wb_last     = 1'b0;
    drain(0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
